// File: rtl/div4_pkg.sv
// Shared types and constants for the 4-bit sequential restoring divider.
// Holds the FSM state encoding, datapath widths and the divide-by-zero quotient.
package div4_pkg;

    localparam int WIDTH   = 4;
    localparam int COUNT_W = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] DIV0_QUOT = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div4_ctrl_sub.sv
// FourBitSubRipple: 4-bit ripple-borrow subtractor, Diff = A1 - B1.
// Ports: A1/B1 operands, Diff difference, No_Borrow high when A1 >= B1.
module FourBitSubRipple (
    input  logic [3:0] A1,
    input  logic [3:0] B1,
    output logic [3:0] Diff,
    output logic       No_Borrow
);

    logic [4:0] bw;

    assign bw[0] = 1'b0;

    for (genvar i = 0; i < 4; i++) begin : g_fs
        assign Diff[i]  = A1[i] ^ B1[i] ^ bw[i];
        assign bw[i+1]  = (~A1[i] & B1[i])
                        | (~(A1[i] ^ B1[i]) & bw[i]);
    end

    assign No_Borrow = ~bw[4];

endmodule

// File: rtl/seq_div4_ctrl.sv
// seq_div4_ctrl: restoring 4-bit unsigned divider, one quotient bit per cycle
// through a single shared FourBitSubRipple instance.
// Ports: clk, rst (async, active high); start/dividend/divisor request;
// busy (CALC), done (1-cycle pulse), quotient/remainder (held), div_err.
// Optional: `define DIV_ZERO_DETECT_EN short-circuits divisor==0 to DONE
// with div_err=1; otherwise div_err is tied low.
import div4_pkg::*;

module seq_div4_ctrl (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_err
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [WIDTH-1:0]   qacc_q, qacc_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   s;
    logic [WIDTH-1:0]   diff;
    logic               no_borrow;
    logic [WIDTH-1:0]   r_calc;
    logic [WIDTH-1:0]   q_calc;

    // Shift the next dividend bit into the partial remainder. R stays below
    // the dividend prefix, so R[3] is always 0 here and S fits in 4 bits.
    assign s = {r_q[WIDTH-2:0], a_q[cnt_q]};

    FourBitSubRipple u_sub (
        .A1        (s),
        .B1        (b_q),
        .Diff      (diff),
        .No_Borrow (no_borrow)
    );

    // Restore on borrow: keep S, otherwise take the difference.
    assign r_calc = no_borrow ? diff : s;

    always_comb begin
        q_calc        = qacc_q;
        q_calc[cnt_q] = no_borrow;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            qacc_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            qacc_q  <= qacc_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        qacc_d  = qacc_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = dividend;
                    b_d     = divisor;
                    r_d     = '0;
                    qacc_d  = '0;
                    cnt_d   = COUNT_W'(WIDTH - 1);
                    err_d   = 1'b0;
                    state_d = CALC;
`ifdef DIV_ZERO_DETECT_EN
                    if (divisor == '0) begin
                        quot_d  = DIV0_QUOT;
                        rem_d   = dividend;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                r_d    = r_calc;
                qacc_d = q_calc;
                if (cnt_q == '0) begin
                    // Results are published only on entry to DONE.
                    quot_d  = q_calc;
                    rem_d   = r_calc;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q == CALC);
    assign done      = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;

`ifdef DIV_ZERO_DETECT_EN
    assign div_err = err_q;
`else
    logic err_unused;
    assign err_unused = err_q;
    assign div_err    = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div4_ctrl.sv
// Self-checking bench for seq_div4_ctrl: vector table, hand-written
// reset/handshake/div-by-zero sequences, exhaustive sweep and random pairs.
module tb_seq_div4_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_err;

    int checks   = 0;
    int failures = 0;

`ifdef DIV_ZERO_DETECT_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif

    always #5 clk = ~clk;

    seq_div4_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_err   (div_err)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [3:0] ref_q(input int a, input int b);
        if (b == 0) return 4'hF;
        return 4'(a / b);
    endfunction

    function automatic logic [3:0] ref_r(input int a, input int b);
        if (b == 0) return 4'(a);
        return 4'(a % b);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic do_div(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er,
                          input string nm);
        int lat;
        int busyc;
        int viol;
        logic [3:0] pq;
        logic [3:0] pr;
        bit short_path;
        short_path = DZ && (b == 4'd0);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pq    = quotient;
        pr    = remainder;
        lat   = 0;
        busyc = 0;
        viol  = 0;
        while (!done && lat < 12) begin
            if (busy) busyc++;
            if (busy && (quotient !== pq || remainder !== pr)) viol++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) begin
            chk({nm, "_timeout"}, 0, 1);
            return;
        end
        chk({nm, "_lat"}, lat, short_path ? 0 : 4);
        chk({nm, "_busy"}, busyc, short_path ? 0 : 4);
        if (!short_path) chk({nm, "_hold"}, viol, 0);
        chk({nm, "_q"}, quotient, eq);
        chk({nm, "_r"}, remainder, er);
        chk({nm, "_err"}, div_err, short_path);
        @(posedge clk);
        #1;
        chk({nm, "_pulse"}, done, 0);
    endtask

    initial begin
        int dcount;
        int consec;
        int first;
        int second;
        int pdone;
        int ndone;
        logic [3:0] ra;
        logic [3:0] rb;

        tbl[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1};
        tbl[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0};
        tbl[2] = '{a: 4'd7,  b: 4'd9,  q: 4'd0,  r: 4'd7};
        tbl[3] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0};
        tbl[4] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0};
        tbl[5] = '{a: 4'd6,  b: 4'd2,  q: 4'd3,  r: 4'd0};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_err", div_err, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            do_div(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, $sformatf("tbl%0d", i));

        // Reset during the second CALC cycle
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_q", quotient, 0);
        chk("mid_r", remainder, 0);
        chk("mid_err", div_err, 0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("mid_nodone", ndone, 0);
        do_div(4'd6, 4'd2, 4'd3, 4'd0, "after_rst");

        // Start held high, operands changed while busy
        @(negedge clk);
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        dividend = 4'd9;
        divisor  = 4'd2;
        dcount = 0;
        consec = 0;
        first  = -1;
        second = -1;
        pdone  = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (pdone != 0) consec++;
                if (dcount == 0) begin
                    first = i;
                    chk("hs1_q", quotient, 4);
                    chk("hs1_r", remainder, 2);
                end else if (dcount == 1) begin
                    second = i;
                    chk("hs2_q", quotient, 4);
                    chk("hs2_r", remainder, 1);
                end
                dcount++;
            end
            pdone = done ? 1 : 0;
            if (i == 10) start = 1'b0;
        end
        chk("hs_first", first, 4);
        chk("hs_space", second - first, 6);
        chk("hs_count", dcount, 2);
        chk("hs_consec", consec, 0);
        repeat (3) @(posedge clk);
        #1;

        // Divide by zero, then a normal op clears div_err
        do_div(4'd9, 4'd0, 4'd15, 4'd9, "div0");
        do_div(4'd5, 4'd2, 4'd2, 4'd1, "post_div0");

        for (int a = 0; a < 16; a++)
            for (int b = 1; b < 16; b++)
                do_div(4'(a), 4'(b), ref_q(a, b), ref_r(a, b),
                       $sformatf("sw_%0d_%0d", a, b));

        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            do_div(ra, rb, ref_q(ra, rb), ref_r(ra, rb),
                   $sformatf("rnd_%0d_%0d", ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
